// File: rtl/mips_muldiv_unit_pkg.sv
// Shared types for the MIPS multiply/divide unit: R-type funct codes, FSM states
// and the decoded operation class.
package mips_muldiv_unit_pkg;

  typedef enum logic [5:0] {
    MFHI  = 6'h10,
    MTHI  = 6'h11,
    MFLO  = 6'h12,
    MTLO  = 6'h13,
    MULT  = 6'h18,
    MULTU = 6'h19,
    DIV   = 6'h1A,
    DIVU  = 6'h1B
  } mips_funct_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_e;

  typedef enum logic [2:0] {
    MD_NONE,
    MD_MUL,
    MD_DIV,
    MD_MTHI,
    MD_MTLO,
    MD_MFHI,
    MD_MFLO
  } muldiv_op_e;

endpackage

// File: rtl/mips_muldiv_unit_decoder.sv
// Combinational funct decode into a mul/div operation class plus signedness.
// Shared with the main control FSM so it can make the same stall decisions.
module mips_muldiv_unit_decoder
  import mips_muldiv_unit_pkg::*;
(
  input  logic [5:0] funct_i,
  output muldiv_op_e op_o,
  output logic       signed_o
);

  always_comb begin
    op_o     = MD_NONE;
    signed_o = 1'b0;
    case (funct_i)
      MULT:    begin op_o = MD_MUL; signed_o = 1'b1; end
      MULTU:   op_o = MD_MUL;
      DIV:     begin op_o = MD_DIV; signed_o = 1'b1; end
      DIVU:    op_o = MD_DIV;
      MTHI:    op_o = MD_MTHI;
      MTLO:    op_o = MD_MTLO;
      MFHI:    op_o = MD_MFHI;
      MFLO:    op_o = MD_MFLO;
      default: op_o = MD_NONE;
    endcase
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Signed ops run on magnitudes
// for DATA_W cycles, then signs are applied in a single fix-up cycle.
module mips_muldiv_unit
  import mips_muldiv_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit DIV_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] rd_data,
  output logic              stall
);

  localparam int CNT_W = $clog2(DATA_W);

  function automatic logic [DATA_W-1:0] cond_neg_w(input logic [DATA_W-1:0] x, input logic en);
    return en ? (~x + DATA_W'(1)) : x;
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg_2w(input logic [2*DATA_W-1:0] x, input logic en);
    return en ? (~x + (2*DATA_W)'(1)) : x;
  endfunction

  muldiv_op_e dec_op;
  logic       dec_signed;

  mips_muldiv_unit_decoder u_dec (
    .funct_i  (funct),
    .op_o     (dec_op),
    .signed_o (dec_signed)
  );

  muldiv_state_e       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dz_q, dz_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  // Operand capture: magnitudes for signed ops, raw values otherwise
  logic              sa, sb;
  logic [DATA_W-1:0] abs_a, abs_b;
  assign sa    = dec_signed & rs_data[DATA_W-1];
  assign sb    = dec_signed & rt_data[DATA_W-1];
  assign abs_a = cond_neg_w(rs_data, sa);
  assign abs_b = cond_neg_w(rt_data, sb);

  // Iteration datapath: shift-add multiply, restoring shift-subtract divide
  logic [DATA_W-1:0]   mul_add;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     div_shift, div_diff;
  assign mul_add   = acc_q[0] ? a_q : '0;
  assign mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, mul_add};
  assign mul_next  = {mul_sum, acc_q[DATA_W-1:1]};
  assign div_shift = {rem_q, acc_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, b_q};

  // Sign fix-up results
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;
  assign prod_fix = cond_neg_2w(acc_q, neg_res_q);
  assign quo_fix  = dz_q ? '1 : cond_neg_w(acc_q[DATA_W-1:0], neg_res_q);
  assign rem_fix  = cond_neg_w(rem_q, neg_rem_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (dec_op)
            MD_MUL, MD_DIV: begin
              if (dec_op == MD_DIV && !DIV_EN) begin
                done_d = 1'b1;
              end else begin
                is_div_d  = (dec_op == MD_DIV);
                neg_res_d = sa ^ sb;
                neg_rem_d = sa;
                dz_d      = (rt_data == '0);
                a_d       = abs_a;
                b_d       = abs_b;
                acc_d     = {{DATA_W{1'b0}}, (dec_op == MD_DIV) ? abs_a : abs_b};
                rem_d     = '0;
                cnt_d     = CNT_W'(DATA_W - 1);
                state_d   = CALC;
              end
            end
            MD_MTHI: begin hi_d = rs_data; done_d = 1'b1; end
            MD_MTLO: begin lo_d = rs_data; done_d = 1'b1; end
            default: ;
          endcase
        end
      end
      CALC: begin
        if (is_div_q) begin
          if (!div_diff[DATA_W]) begin
            rem_d = div_diff[DATA_W-1:0];
            acc_d = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = div_shift[DATA_W-1:0];
            acc_d = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_next;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        // HI/LO are written on this edge so they are valid alongside done
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*DATA_W-1:DATA_W];
          lo_d = prod_fix[DATA_W-1:0];
        end
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC) || (state_d == FIX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = (dec_op == MD_MFHI) ? hi_q :
                   (dec_op == MD_MFLO) ? lo_q : '0;
  assign stall   = busy_q & ((dec_op == MD_MFHI) | (dec_op == MD_MFLO));

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit for the multi-cycle MIPS datapath. It generalises the ALU decode path to multi-cycle R-type ops: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- Owns the HI/LO registers and sequences each operation with a start/busy/done handshake.
- Sits beside the ALU. The main control FSM issues start and holds its execute state until done.

Parameters:
- DATA_W, 32, operand/HI/LO width; any even value >= 4.
- DIV_EN, 1, 0 removes the divider path; DIV/DIVU then complete as no-ops (done after 1 cycle, HI/LO unchanged).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- funct  input  mips_funct_e (6)  R-type funct of the issued instruction.
- rs_data  input  DATA_W  operand A (dividend / multiplicand / MTHI-MTLO source).
- rt_data  input  DATA_W  operand B (divisor / multiplier).
- busy  output  1  high while an iterative op is in flight.
- done  output  1  single-cycle pulse when an op completes.
- hi  output  DATA_W  HI register.
- lo  output  DATA_W  LO register.
- rd_data  output  DATA_W  combinational: hi when funct=MFHI, lo when funct=MFLO, else 0.
- stall  output  1  busy & (funct==MFHI | funct==MFLO); control must not write rd while high.

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-op):
  - state=IDLE; busy=0, done=0.
  - hi=0, lo=0; internal accumulators cleared.
  - Op in flight is discarded; no partial HI/LO update.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 with MULT/MULTU/DIV/DIVU → CALC. Latch |A|, |B| (signed ops) or raw A, B (unsigned ops), plus result sign flags; iteration counter = DATA_W-1.
  - start=1 with MTHI/MTLO → hi (resp. lo) = rs_data at the next edge; done=1 in that cycle; stays IDLE.
  - start=1 with MFHI/MFLO or any other funct → ignored; done stays 0.
- CALC: one iteration per cycle; counter decrements; at counter 0 → FIX.
  - Multiply: shift-add, 2*DATA_W-bit product register.
  - Divide: restoring shift-subtract; remainder DATA_W+1 bits.
- FIX: apply signs.
  - Product negated if signA^signB.
  - Quotient negated if signA^signB; remainder takes sign of A.
  - → DONE.
- DONE:
  - Multiply: hi/lo = product[2W-1:W] / product[W-1:0].
  - Divide: lo = quotient, hi = remainder.
  - done=1 for exactly this cycle, then → IDLE.
- busy=1 in CALC and FIX, 0 in DONE and IDLE.
- Latency: start at edge n → done high in cycle n+DATA_W+2 (34 for DATA_W=32), with hi/lo valid in that same cycle.
- start while busy=1 → ignored. Operands and funct are not re-sampled; the control FSM must hold them stable only at the start cycle.
- Divide by zero (rt_data=0): completes with normal latency; hi=rs_data, lo=all ones. No exception.
- Signed overflow DIV (-2^(W-1) / -1): lo=0x8000_0000, hi=0 (truncated result); no flag.
- MTHI/MTLO issued in the same cycle an iterative op reaches DONE cannot occur: start is only sampled in IDLE.
- stall and rd_data are purely combinational; every other output is registered.

Decomposition:
- MIPS_pkg: add mips_funct_e members MFHI=6'h10, MTHI=6'h11, MFLO=6'h12, MTLO=6'h13, MULT=6'h18, MULTU=6'h19, DIV=6'h1A, DIVU=6'h1B.
- New muldiv_pkg:
  - muldiv_state_e {IDLE, CALC, FIX, DONE}.
  - muldiv_op_e {MD_NONE, MD_MUL, MD_DIV, MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO}, plus a signed flag.
- One sub-module: muldiv_decoder, combinational funct → {muldiv_op_e, is_signed}. Counterpart of the existing ALU decoder; reused by the control FSM for stall decisions.

Test Plan:
- MULT, rs=0xFFFFFFFF, rt=7 → done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFF9; busy high cycles 1–33.
- MULTU, same operands → hi=0x00000006, lo=0xFFFFFFF9.
- DIV, rs=0xFFFFFFF9 (-7), rt=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU rs=100, rt=0 → hi=100, lo=0xFFFFFFFF.
- MTHI rs=0x12345678 → hi=0x12345678 one cycle later, done pulse, busy never asserted. Then MFHI → rd_data=0x12345678, stall=0.
- MULT issued; at cycle 5 assert start with DIV, and funct=MFLO → DIV ignored, stall=1, rd_data=old lo. Original MULT result written at cycle 34.
- DIV in flight; rst=1 at cycle 10 → next cycle busy=0, done=0, hi=lo=0, done never pulses. A fresh MULTU 3×5 then gives lo=15, hi=0.
